// File: rtl/rf_cmd_master.sv
// Requester-side controller for the 8-entry register-file slave: one slave access per command,
// registered response on a valid/ready channel. Define RF_VERIFY_EN to read back and verify every write.
module rf_cmd_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_unset,
  output logic              rf_wr,
  output logic              rf_rd,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_dout,
  input  logic              rf_error,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef RF_VERIFY_EN
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, V_ISSUE, V_CAPTURE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
`endif

  state_t           state_q, state_d;
  logic             op_q;
  logic [DEPTH-1:0] written_q;

  // NOTE: next-state logic assigns every output a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_wr     = 1'b0;
    rf_rd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = resetn;
        if (cmd_valid) state_d = ISSUE;
      end
      ISSUE: begin
        rf_wr   = op_q;
        rf_rd   = ~op_q;
        state_d = CAPTURE;
      end
      CAPTURE: begin
`ifdef RF_VERIFY_EN
        state_d = op_q ? V_ISSUE : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef RF_VERIFY_EN
      V_ISSUE: begin
        rf_rd   = 1'b1;
        state_d = V_CAPTURE;
      end
      V_CAPTURE: state_d = RESP;
`endif
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // rf_addr/rf_din double as the command latch: they change only on acceptance,
  // so they hold their last driven values between accesses.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the written bitmap is reset with the rest of the state; it must read as all-clear after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      rf_addr   <= '0;
      rf_din    <= '0;
      written_q <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_unset <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            rf_addr <= cmd_addr;
            rf_din  <= cmd_data;
          end
        end
        ISSUE: begin
          if (op_q) written_q[rf_addr] <= 1'b1;
        end
        CAPTURE: begin
          rsp_err   <= rf_error;
          rsp_data  <= op_q ? rf_din : rf_dout;
          rsp_unset <= ~op_q & ~written_q[rf_addr];
        end
`ifdef RF_VERIFY_EN
        V_CAPTURE: begin
          rsp_err <= rsp_err | rf_error | (rf_dout != rf_din);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
